// File: rtl/bin2bcd_digit_writer.sv
// Binary-to-BCD converter (sequential double-dabble) feeding the seven-segment
// display digit register file through its num/sel/wr write port.
module bin2bcd_digit_writer #(
    parameter int unsigned BIN_W   = 27,
    parameter int unsigned DIGITS  = 8,
    parameter int unsigned MAX_VAL = 99999999,
    localparam int unsigned SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             wr,
    output logic [SEL_W-1:0] sel,
    output logic [3:0]       num
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned IDX_W = $clog2(DIGITS + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        WRITE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               wr_q, wr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [3:0]         num_q, num_d;

    logic               over;
    logic [BCD_W-1:0]   adj;
    logic [3:0]         digit;

    assign over = (bin_in > MAX_V);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = over ? WRITE : CONVERT;
            CONVERT: if (cnt_q == CNT_W'(1)) state_d = WRITE;
            WRITE:   if (idx_q == IDX_W'(DIGITS)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // WRITE issues digit idx_q into the output registers, so the strobe trails the
    // state by one cycle; the extra slot idx_q == DIGITS retires the strobe and raises done.
    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        done_d = 1'b0;
        ovf_d  = ovf_q;
        wr_d   = wr_q;
        sel_d  = sel_q;
        num_d  = num_q;

        adj = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                      : bcd_q[4*k +: 4];
        end

        digit = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) digit = bcd_q[4*k +: 4];
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    bin_d  = bin_in;
                    bcd_d  = '0;
                    cnt_d  = CNT_W'(BIN_W);
                    idx_d  = '0;
                    busy_d = 1'b1;
                    ovf_d  = over;
                end
            end
            CONVERT: begin
                bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
            end
            WRITE: begin
                if (idx_q == IDX_W'(DIGITS)) begin
                    wr_d   = 1'b0;
                    done_d = 1'b1;
                end else begin
                    wr_d  = 1'b1;
                    sel_d = idx_q[SEL_W-1:0];
                    num_d = ovf_q ? 4'hE : digit;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
                wr_d   = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign wr   = wr_q;
    assign sel  = sel_q;
    assign num  = num_q;

endmodule

// File: tb/tb_bin2bcd_digit_writer.sv
// Directed self-checking bench for bin2bcd_digit_writer: write bursts, latency,
// overflow, busy-start rejection, mid-write reset and back-to-back starts.
module tb_bin2bcd_digit_writer;

    logic        CLK = 1'b0;
    logic        rst;
    logic        start;
    logic [26:0] bin_in;
    logic        busy, done, ovf, wr;
    logic [2:0]  sel;
    logic [3:0]  num;

    bin2bcd_digit_writer #(
        .BIN_W  (27),
        .DIGITS (8),
        .MAX_VAL(99999999)
    ) dut (
        .CLK   (CLK),
        .rst   (rst),
        .start (start),
        .bin_in(bin_in),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .wr    (wr),
        .sel   (sel),
        .num   (num)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    int         wr_cnt, done_cnt, done_cyc, busy_low;
    int         wr_cyc [16];
    logic [2:0] wr_sel [16];
    logic [3:0] wr_num [16];
    logic       busy0, ovf_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [26:0] value, input logic hold);
        @(negedge CLK);
        bin_in = value;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) begin
            start  = 1'b0;
            bin_in = ~value;
        end
    endtask

    // Cycle 0 is the accepting edge; each cycle is sampled on the falling edge.
    task automatic capture(input int ncyc, input int pa, input int pb, input int rst_cyc);
        wr_cnt   = 0;
        done_cnt = 0;
        done_cyc = -1;
        busy_low = -1;
        for (int i = 0; i < 16; i++) begin
            wr_cyc[i] = -1;
            wr_sel[i] = 'x;
            wr_num[i] = 'x;
        end
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) @(posedge CLK);
            @(negedge CLK);
            if (c == 0) busy0 = busy;
            if (wr) begin
                if (wr_cnt < 16) begin
                    wr_cyc[wr_cnt] = c;
                    wr_sel[wr_cnt] = sel;
                    wr_num[wr_cnt] = num;
                end
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (!busy && busy_low < 0) busy_low = c;
            ovf_last = ovf;
            if (pa >= 0 && (c == pa || c == pb)) start = 1'b1;
            else if (pa >= 0 && (c == pa + 1 || c == pb + 1)) start = 1'b0;
            if (rst_cyc >= 0 && c == rst_cyc) rst = 1'b1;
            else if (rst_cyc >= 0 && c == rst_cyc + 1) rst = 1'b0;
        end
    endtask

    task automatic verify(input string tag, input int first, input logic [31:0] digits,
                          input logic exp_ovf);
        check({tag, " busy0"}, 32'(busy0), 32'd1);
        check({tag, " wr_count"}, wr_cnt, 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s cyc%0d", tag, k), wr_cyc[k], first + k);
            check($sformatf("%s sel%0d", tag, k), 32'(wr_sel[k]), k);
            check($sformatf("%s num%0d", tag, k), 32'(wr_num[k]), 32'(digits[4*k +: 4]));
        end
        check({tag, " done_count"}, done_cnt, 32'd1);
        check({tag, " done_cycle"}, done_cyc, first + 8);
        check({tag, " busy_low"}, busy_low, first + 9);
        check({tag, " ovf"}, 32'(ovf_last), 32'(exp_ovf));
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst ovf",  32'(ovf),  32'd0);
        check("rst wr",   32'(wr),   32'd0);
        check("rst sel",  32'(sel),  32'd0);
        check("rst num",  32'(num),  32'd0);
        rst = 1'b0;

        launch(27'd0, 1'b0);
        capture(40, -1, -1, -1);
        verify("zero", 28, 32'h00000000, 1'b0);

        launch(27'd12345678, 1'b0);
        capture(40, -1, -1, -1);
        verify("v12345678", 28, 32'h12345678, 1'b0);

        launch(27'd99999999, 1'b0);
        capture(40, -1, -1, -1);
        verify("max", 28, 32'h99999999, 1'b0);

        launch(27'd100000000, 1'b0);
        capture(20, -1, -1, -1);
        verify("over", 1, 32'hEEEEEEEE, 1'b1);

        launch(27'd7, 1'b0);
        capture(60, 5, 20, -1);
        verify("busy_start", 28, 32'h00000007, 1'b0);

        launch(27'd12345678, 1'b0);
        capture(45, -1, -1, 31);
        check("abort wr_count", wr_cnt, 32'd4);
        check("abort sel3", 32'(wr_sel[3]), 32'd3);
        check("abort num3", 32'(wr_num[3]), 32'd5);
        check("abort done_count", done_cnt, 32'd0);
        check("abort busy_low", busy_low, 32'd32);

        launch(27'd42, 1'b0);
        capture(40, -1, -1, -1);
        verify("after_abort", 28, 32'h00000042, 1'b0);

        launch(27'd305, 1'b1);
        capture(37, -1, -1, -1);
        verify("b2b_first", 28, 32'h00000305, 1'b0);
        @(posedge CLK);
        #1;
        start  = 1'b0;
        bin_in = 27'd1234;
        capture(40, -1, -1, -1);
        verify("b2b_second", 28, 32'h00000305, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_digit_writer.md
Name: bin2bcd_digit_writer

Overview:
Upstream feeder for the 8-digit seven-segment display controller. It converts a binary value to eight BCD digits using sequential double-dabble (shift-add-3). It then writes the digits one per cycle into the display's digit register file through that block's num/sel/wr write port. Out-of-range values are written as all 'E' digits (code 4'hE).

Parameters:
BIN_W, 27, width of the binary input; 27 bits covers 0..99,999,999.
DIGITS, 8, number of BCD digits produced and written; sel width is 3 for the default.
MAX_VAL, 99999999, largest value displayed normally; anything above is overflow.

Ports:
CLK  input  1  system clock, rising-edge; the same clock as the display controller.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
bin_in  input  BIN_W  binary value; latched on the accepted start edge.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the last digit write.
ovf  output  1  registered overflow flag for the latched value; held until the next accepted start.
wr  output  1  write strobe to the display register file.
sel  output  3  digit index being written; 0 = least-significant digit.
num  output  4  BCD digit value, or 4'hE on overflow.

Behaviour:
- All outputs are registered. Reset (sync, active-high) forces:
  - state=IDLE
  - busy=0, done=0, ovf=0, wr=0, sel=0, num=0
  - internal shift register and BCD accumulator cleared
- Reset mid-operation aborts immediately. No further wr pulses occur. The display keeps any digits already written.
- FSM states: IDLE -> CONVERT -> WRITE -> DONE -> IDLE.
- IDLE:
  - On an edge with start=1: latch bin_in, clear the BCD accumulator (4*DIGITS bits), set busy=1.
  - If bin_in > MAX_VAL: ovf<=1, go to WRITE. CONVERT is skipped; every written num is 4'hE.
  - Otherwise: ovf<=0, go to CONVERT with bit counter = BIN_W.
- CONVERT: one double-dabble step per cycle.
  - Each BCD nibble >= 5 gets +3 (nibbles in parallel).
  - Then shift {bcd, bin} left by 1, MSB of bin first.
  - The counter decrements each step; after exactly BIN_W steps go to WRITE.
  - No carry leaves the top nibble; guaranteed by MAX_VAL.
- WRITE: DIGITS consecutive cycles with wr=1.
  - sel=k and num=digit k for k = 0,1,...,DIGITS-1, in that order.
  - sel/num/wr change together on the same edge; there are no gaps.
  - After k = DIGITS-1 go to DONE; wr<=0 on the following edge.
- DONE: done=1 for one cycle, busy still 1. Next edge: IDLE, busy=0, done=0.
- Latency, counting start-accepting edge = cycle 0:
  - Normal: wr high in cycles BIN_W+1 .. BIN_W+DIGITS (28..35); done in cycle 36; busy low from cycle 37.
  - Overflow: wr high in cycles 1..8; done in cycle 9.
- start while busy is ignored, not queued. start held high in IDLE re-triggers on the first IDLE cycle.
- bin_in changes after the accepting edge have no effect.
- When wr=0, sel and num hold their last values. The display only samples them when wr=1.

Test Plan:
- rst high 3 cycles then low; start=1, bin_in=0 -> 8 wr cycles, sel 0..7, num=0 each; done at cycle 36; ovf=0.
- bin_in=12345678 -> writes (sel,num) = (0,8),(1,7),(2,6),(3,5),(4,4),(5,3),(6,2),(7,1), consecutive cycles 28..35; done cycle 36.
- Boundary: bin_in=99999999 -> all num=9, ovf=0. bin_in=100000000 -> ovf=1, all num=4'hE, wr cycles 1..8, done cycle 9.
- bin_in=7 then start pulsed at cycles 5 and 20 while busy -> only one write burst: (0,7) then 0 for sel 1..7; exactly one done pulse.
- Reset mid-WRITE: assert rst during the cycle sel=3 is written -> next edge wr=0, busy=0, done never pulses. A new start with bin_in=42 then completes normally: (0,2),(1,4), rest 0.
- Back-to-back: start held high continuously with bin_in=305 -> a second conversion begins on the first IDLE cycle after done; both bursts write (0,5),(1,0),(2,3), rest 0.
